// File: rtl/mb32_spram_if.sv
// mb32_io bus: a master drives we/bmsk/ai/vi, the slave returns vo.
// Sizing is fixed at 32-bit data and a 15-bit word address.
interface mb32_io (
    input logic clk
);
    logic        we;
    logic [3:0]  bmsk;
    logic [14:0] ai;
    logic [31:0] vi;
    logic [31:0] vo;

    modport master (
        input  clk,
        output we,
        output bmsk,
        output ai,
        output vi,
        input  vo
    );

    modport slave (
        input  clk,
        input  we,
        input  bmsk,
        input  ai,
        input  vi,
        output vo
    );
endinterface

// File: rtl/mb32_spram.sv
// 32K x 32 mb32_io slave memory built from four 16K x 16 SPRAM blocks (two banks of lo/hi).
// Optional post-reset clear sequencer enabled by defining MB32_SPRAM_CLEAR_EN.

module mb32_spram_blk (
    input  logic        clk_i,
    input  logic [13:0] addr_i,
    input  logic [15:0] din_i,
    input  logic [3:0]  maskwren_i,
    input  logic        wren_i,
    input  logic        cs_i,
    input  logic        standby_i,
    input  logic        sleep_i,
    input  logic        poweroff_i,
    output logic [15:0] dout_o
);
    logic [15:0] mem_q [16384];
    logic [15:0] dout_q;

    // Single SPRAM port: nibble-masked write, otherwise registered read; output holds when idle.
    always_ff @(posedge clk_i) begin
        if (cs_i && poweroff_i && !sleep_i && !standby_i) begin
            if (wren_i) begin
                for (int n = 0; n < 4; n++) begin
                    if (maskwren_i[n]) begin
                        mem_q[addr_i][n*4 +: 4] <= din_i[n*4 +: 4];
                    end
                end
            end else begin
                dout_q <= mem_q[addr_i];
            end
        end
    end

    assign dout_o = dout_q;
endmodule

module mb32_spram #(
    parameter logic [15:0] CLR_VAL  = 16'h0000,
    parameter logic [13:0] CLR_LAST = 14'd16383
) (
    input  logic  clk,
    input  logic  rst_n,
    mb32_io.slave b,
    output logic  rdy
);
    // Byte enables expand to SPRAM nibble enables: {hi[3:2],hi[1:0],lo[3:2],lo[1:0]}.
    function automatic logic [7:0] bmsk_to_nib(input logic [3:0] m);
        return {{2{m[3]}}, {2{m[2]}}, {2{m[1]}}, {2{m[0]}}};
    endfunction

    logic        rdy_q;
    logic        clr_en_s;
    logic [13:0] clr_addr_s;

    logic        req_en_s;
    logic [13:0] addr_s;
    logic [31:0] din_s;
    logic [7:0]  msk_s;
    logic        wren_s;
    logic [1:0]  cs_s;

    logic [15:0] dout_lo_s [2];
    logic [15:0] dout_hi_s [2];

    logic        rd_pend_q;
    logic        bank_q;
    logic [31:0] vo_q;
    logic [31:0] vo_d;

`ifdef MB32_SPRAM_CLEAR_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t      state_q;
    logic [13:0] cnt_q;

    // Clear sequencer: walks cnt_q over every SPRAM word, then opens the bus via rdy_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= 14'd0;
            rdy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_CLEAR;
                    cnt_q   <= 14'd0;
                    rdy_q   <= 1'b0;
                end
                ST_CLEAR: begin
                    if (cnt_q == CLR_LAST) begin
                        state_q <= ST_READY;
                        rdy_q   <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + 14'd1;
                        rdy_q   <= 1'b0;
                    end
                end
                ST_READY: begin
                    rdy_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 14'd0;
                    rdy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign clr_en_s   = rst_n && (state_q == ST_CLEAR);
    assign clr_addr_s = cnt_q;
`else
    logic unused_cfg_s;

    // Without the sequencer the bus opens on the first edge out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    assign clr_en_s     = 1'b0;
    assign clr_addr_s   = 14'd0;
    assign unused_cfg_s = ^{CLR_VAL, CLR_LAST};
`endif

    // SPRAM port steering: the clear pass owns all four blocks, else the addressed bank only.
    always_comb begin
        req_en_s = rst_n && rdy_q;
        if (clr_en_s) begin
            addr_s = clr_addr_s;
            din_s  = {CLR_VAL, CLR_VAL};
            msk_s  = 8'hFF;
            wren_s = 1'b1;
            cs_s   = 2'b11;
        end else begin
            addr_s = b.ai[13:0];
            din_s  = b.vi;
            msk_s  = bmsk_to_nib(b.bmsk);
            wren_s = req_en_s && b.we;
            if (req_en_s) begin
                cs_s = b.ai[14] ? 2'b10 : 2'b01;
            end else begin
                cs_s = 2'b00;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        mb32_spram_blk u_lo (
            .clk_i      (clk),
            .addr_i     (addr_s),
            .din_i      (din_s[15:0]),
            .maskwren_i (msk_s[3:0]),
            .wren_i     (wren_s),
            .cs_i       (cs_s[g]),
            .standby_i  (1'b0),
            .sleep_i    (1'b0),
            .poweroff_i (1'b1),
            .dout_o     (dout_lo_s[g])
        );

        mb32_spram_blk u_hi (
            .clk_i      (clk),
            .addr_i     (addr_s),
            .din_i      (din_s[31:16]),
            .maskwren_i (msk_s[7:4]),
            .wren_i     (wren_s),
            .cs_i       (cs_s[g]),
            .standby_i  (1'b0),
            .sleep_i    (1'b0),
            .poweroff_i (1'b1),
            .dout_o     (dout_hi_s[g])
        );
    end

    // vo only moves on the edge after a read's SPRAM access, so it holds across writes and idle.
    always_comb begin
        if (rd_pend_q) begin
            vo_d = {dout_hi_s[bank_q], dout_lo_s[bank_q]};
        end else begin
            vo_d = vo_q;
        end
    end

    // Read tracking and output register; reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend_q <= 1'b0;
            bank_q    <= 1'b0;
            vo_q      <= 32'h0000_0000;
        end else begin
            rd_pend_q <= req_en_s && !b.we;
            if (req_en_s && !b.we) begin
                bank_q <= b.ai[14];
            end
            vo_q <= vo_d;
        end
    end

    assign b.vo = vo_q;
    assign rdy  = rdy_q;
endmodule

// File: tb/tb_mb32_spram.sv
// Directed bench for mb32_spram; clear-sequencer checks run when MB32_SPRAM_CLEAR_EN is defined.
module tb_mb32_spram;
    logic clk = 1'b0;
    logic rst_n;
    logic rdy;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] rd;
    logic [31:0] last_vo;

    always #5 clk = ~clk;

    mb32_io bus_if (.clk(clk));

    mb32_spram #(
        .CLR_VAL  (16'h0000),
        .CLR_LAST (14'd7)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .b     (bus_if),
        .rdy   (rdy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_idle();
        bus_if.we   = 1'b1;
        bus_if.bmsk = 4'h0;
        bus_if.ai   = 15'h0000;
        bus_if.vi   = 32'h0000_0000;
    endtask

    task automatic bus_write(input logic [14:0] a, input logic [31:0] d, input logic [3:0] m);
        bus_if.we   = 1'b1;
        bus_if.bmsk = m;
        bus_if.ai   = a;
        bus_if.vi   = d;
        step();
        drv_idle();
    endtask

    task automatic bus_read(input logic [14:0] a, output logic [31:0] d);
        bus_if.we   = 1'b0;
        bus_if.bmsk = 4'h0;
        bus_if.ai   = a;
        step();
        drv_idle();
        step();
        d = bus_if.vo;
    endtask

    // Checks rdy stays low for `lim` edges and rises on exactly the last one.
    task automatic check_rdy_seq(input string tag, input int lim);
        check_val(tag, {31'd0, rdy}, 32'd0);
        for (int k = 1; k <= lim; k++) begin
            step();
            check_val(tag, {31'd0, rdy}, (k >= lim) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic wait_rdy(input string tag);
        int cyc = 0;
        while (rdy !== 1'b1 && cyc < 50) begin
            step();
            cyc++;
        end
        check_val(tag, {31'd0, rdy}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        drv_idle();
        step();
        step();
        check_val("rst_rdy", {31'd0, rdy}, 32'd0);
        check_val("rst_vo", bus_if.vo, 32'h0000_0000);
        rst_n = 1'b1;

`ifdef MB32_SPRAM_CLEAR_EN
        check_rdy_seq("clr_rdy1", 8);
        for (int i = 0; i < 8; i++) begin
            bus_write(15'(i), 32'hA5A5_A5A5, 4'hF);
            bus_write(15'(15'h4000 + i), 32'hA5A5_A5A5, 4'hF);
        end
        bus_write(15'h0020, 32'hA5A5_A5A5, 4'hF);
        bus_read(15'h0005, rd);
        check_val("preload", rd, 32'hA5A5_A5A5);

        rst_n = 1'b0;
        step();
        check_val("rst_vo2", bus_if.vo, 32'h0000_0000);
        rst_n = 1'b1;
        bus_if.we   = 1'b1;
        bus_if.bmsk = 4'hF;
        bus_if.ai   = 15'h0020;
        bus_if.vi   = 32'h1234_5678;
        step();
        step();
        drv_idle();
        step();
        step();
        rst_n = 1'b0;
        step();
        check_val("abort_rdy", {31'd0, rdy}, 32'd0);
        check_val("abort_vo", bus_if.vo, 32'h0000_0000);
        rst_n = 1'b1;
        check_rdy_seq("clr_rdy2", 8);

        for (int i = 0; i < 8; i++) begin
            bus_read(15'(i), rd);
            check_val("clr_b0", rd, 32'h0000_0000);
            bus_read(15'(15'h4000 + i), rd);
            check_val("clr_b1", rd, 32'h0000_0000);
        end
        bus_read(15'h0020, rd);
        check_val("gate_wr", rd, 32'hA5A5_A5A5);
        last_vo = 32'hA5A5_A5A5;
`else
        check_val("rel_rdy0", {31'd0, rdy}, 32'd0);
        step();
        check_val("rel_rdy1", {31'd0, rdy}, 32'd1);
        bus_write(15'h0030, 32'h1111_1111, 4'hF);
        rst_n = 1'b0;
        bus_if.we   = 1'b1;
        bus_if.bmsk = 4'hF;
        bus_if.ai   = 15'h0030;
        bus_if.vi   = 32'h9999_9999;
        step();
        rst_n = 1'b1;
        step();
        drv_idle();
        check_val("rel_rdy2", {31'd0, rdy}, 32'd1);
        bus_read(15'h0030, rd);
        check_val("gate_wr", rd, 32'h1111_1111);
        last_vo = 32'h1111_1111;
`endif

        // Latency and hold
        bus_write(15'h0123, 32'hDEAD_BEEF, 4'hF);
        bus_if.we = 1'b0;
        bus_if.ai = 15'h0123;
        step();
        drv_idle();
        check_val("lat_edge_n", bus_if.vo, last_vo);
        step();
        check_val("lat_edge_n1", bus_if.vo, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("hold", bus_if.vo, 32'hDEAD_BEEF);
        end

        bus_write(15'h0123, 32'h1122_3344, 4'b0101);
        bus_read(15'h0123, rd);
        check_val("bmask_0101", rd, 32'hDE22_BE44);
        bus_write(15'h0123, 32'hCAFE_F00D, 4'b1010);
        bus_read(15'h0123, rd);
        check_val("bmask_1010", rd, 32'hCA22_F044);

        bus_write(15'h0010, 32'h0000_0001, 4'hF);
        bus_write(15'h4010, 32'h0000_0002, 4'hF);
        bus_read(15'h0010, rd);
        check_val("bank0", rd, 32'h0000_0001);
        bus_read(15'h4010, rd);
        check_val("bank1", rd, 32'h0000_0002);

        // Reset lands on the edge that would have completed the read
        bus_if.we = 1'b0;
        bus_if.ai = 15'h4010;
        step();
        drv_idle();
        rst_n = 1'b0;
        step();
        check_val("rst_mid_read", bus_if.vo, 32'h0000_0000);
        rst_n = 1'b1;
        wait_rdy("rdy_after_rst");
        bus_read(15'h0010, rd);
        check_val("retain", rd, 32'h0000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
